// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM encodings, default parameters and
// oversampling constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_RECOVER = 3'd4
  } rx_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int OVERSAMPLE  = 16;  // s_ticks per bit
  localparam int START_MID   = 7;   // tick at which the start bit is re-checked
  // Tick counter is 5 bits so stop periods up to 32 ticks (2 stop bits) fit.
  localparam int TICK_W      = 5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_in,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_q;

  // Shift the pin through two flops to resolve metastability.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) ff_q <= 2'b11;
    else           ff_q <= {ff_q[0], async_i};
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, start glitch rejection,
// mid-bit sampling, framing error flag and one-cycle done strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int data_width = DEF_DATA_W,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  rx,
  output logic [data_width-1:0] dout,
  output logic                  rx_done_tick,
  output logic                  framing_err,
  output logic                  rx_busy
);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(START_MID);
  localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_STOP = TICK_W'(SB_TICK - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(data_width - 1);

  rx_state_e             state_q, state_d;
  logic [TICK_W-1:0]     s_q, s_d;
  logic [2:0]            n_q, n_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  rx_s;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset_in (reset_in),
    .async_i  (rx),
    .sync_o   (rx_s)
  );

  // FSM state, tick/bit counters and shift register.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= RX_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
    end
  end

  // Output registers: updated only on commit, strobe for one clk.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      dout_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end
  end

  // Next-state logic; counters only move on s_tick cycles.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          s_d     = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = RX_IDLE;  // glitch: no strobe
            end
          end else begin
            s_d = s_q + TICK_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_q == TICK_BIT) begin
            s_d     = '0;
            shift_d = {rx_s, shift_q[data_width-1:1]};
            if (n_q == LAST_BIT) state_d = RX_STOP;
            else                 n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + TICK_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (s_q == TICK_STOP) begin
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = rx_s ? RX_IDLE : RX_RECOVER;
          end else begin
            s_d = s_q + TICK_W'(1);
          end
        end
      end
      RX_RECOVER: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign framing_err  = ferr_q;
  assign rx_busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8N1 instance plus a 7-bit, 2-stop instance.
module tb_uart_rx;

  localparam int BIT = 64;  // clk per bit: s_tick every 4 clk, 16 ticks/bit

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] dout;
  logic       done, ferr, busy;
  logic [6:0] dout7;
  logic       done7, ferr7, busy7;

  int checks = 0;
  int errors = 0;
  int n0 = 0;
  int n7 = 0;
  int tcnt = 0;
  logic [7:0] got0[$];

  uart_rx dut (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(done), .framing_err(ferr), .rx_busy(busy)
  );

  uart_rx #(.data_width(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done_tick(done7), .framing_err(ferr7), .rx_busy(busy7)
  );

  always #5 clk = ~clk;

  // One-clk s_tick every fourth cycle.
  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    s_tick = (tcnt == 0);
  end

  // Count strobe cycles and log received words.
  always @(negedge clk) begin
    if (done) begin
      n0 = n0 + 1;
      got0.push_back(dout);
    end
    if (done7) n7 = n7 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input bit sel, input logic v, input int clks);
    if (sel) rx7 = v;
    else     rx  = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_data(input bit sel, input logic [7:0] d, input int nbits);
    send_bit(sel, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) send_bit(sel, d[i], BIT);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d);
    send_data(sel, d, 8);
    send_bit(sel, 1'b1, BIT);
  endtask

  function automatic logic [31:0] q_at(input int idx);
    return (got0.size() > idx) ? 32'(got0[idx]) : 32'hDEAD;
  endfunction

  int c, c7, b;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_in = 1'b1;
    repeat (10) @(negedge clk);

    // 1: good frame 0xA5
    c = n0;
    send_frame(0, 8'hA5);
    repeat (BIT) @(negedge clk);
    chk("t1_cnt", n0 - c, 1);
    chk("t1_dout", dout, 8'hA5);
    chk("t1_ferr", ferr, 0);
    chk("t1_busy", busy, 0);

    // 2: start glitch, 5 ticks low
    c = n0;
    send_bit(0, 1'b0, 20);
    send_bit(0, 1'b1, 3 * BIT);
    chk("t2_cnt", n0 - c, 0);
    chk("t2_dout", dout, 8'hA5);
    chk("t2_busy", busy, 0);

    // 3: framing error with line held low, then recovery frame
    c = n0;
    send_data(0, 8'h3C, 8);
    send_bit(0, 1'b0, 3 * BIT);
    chk("t3_busy_low", busy, 1);
    chk("t3_cnt", n0 - c, 1);
    chk("t3_dout", dout, 8'h3C);
    chk("t3_ferr", ferr, 1);
    send_bit(0, 1'b1, BIT);
    chk("t3_busy_high", busy, 0);
    chk("t3_cnt_after", n0 - c, 1);
    c = n0;
    send_frame(0, 8'h81);
    repeat (BIT) @(negedge clk);
    chk("t3_cnt2", n0 - c, 1);
    chk("t3_dout2", dout, 8'h81);
    chk("t3_ferr2", ferr, 0);

    // 4: back-to-back frames, no idle gap
    c = n0;
    b = got0.size();
    send_frame(0, 8'h00);
    send_frame(0, 8'hFF);
    send_frame(0, 8'h55);
    repeat (BIT) @(negedge clk);
    chk("t4_cnt", n0 - c, 3);
    chk("t4_w0", q_at(b), 8'h00);
    chk("t4_w1", q_at(b + 1), 8'hFF);
    chk("t4_w2", q_at(b + 2), 8'h55);

    // 5: reset in the middle of data bit 4
    c = n0;
    send_bit(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(0, 1'(8'h5A >> i), BIT);
    send_bit(0, 1'b1, BIT / 2);
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_dout", dout, 0);
    chk("t5_ferr", ferr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    reset_in = 1'b1;
    send_bit(0, 1'b1, 3 * BIT);
    chk("t5_cnt", n0 - c, 0);
    send_frame(0, 8'h12);
    repeat (BIT) @(negedge clk);
    chk("t5_cnt2", n0 - c, 1);
    chk("t5_dout2", dout, 8'h12);
    chk("t5_ferr2", ferr, 0);

    // 6: 7 data bits, 2 stop bits
    c7 = n7;
    send_data(1, 8'h6B, 7);
    send_bit(1, 1'b1, BIT);
    chk("t6_early", n7 - c7, 0);
    chk("t6_busy_stop", busy7, 1);
    send_bit(1, 1'b1, BIT);
    chk("t6_cnt", n7 - c7, 1);
    chk("t6_dout", dout7, 7'h6B);
    chk("t6_ferr", ferr7, 0);
    chk("t6_busy", busy7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
